eco_patch_unit: RTL and testbench
=================================

Name: eco_patch_unit

Overview:
- Registered, programmable ECO rectification stage that sits between a combinational logic cone and its capture flops.
- Each output bit is XOR-corrected by a sum-of-products patch built from up to TERMS cube terms over the cone's primary inputs.
- Terms are loaded at run time into a shadow table through a valid/ready interface, then committed atomically to the active table.
- Generalises the fixed single-patch netlist style to any width and term count, and adds bypass, double-buffering and hit counting.

Parameters:
- IN_W, 10, width of primary-input vector {A,B} fed to the cube matcher
- OUT_W, 3, width of base output vector and patched output
- TERMS, 4, number of programmable cube terms (power of two, 2..16)
- CNT_W, 16, width of saturating patch-hit counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  primary input and base output valid this cycle
- in_vec  in  IN_W  primary inputs of the cone
- base_y  in  OUT_W  unpatched cone output
- out_valid  out  1  patched output valid
- out_y  out  OUT_W  patched output
- cfg_valid  in  1  shadow-table write request
- cfg_ready  out  1  shadow table accepts a write
- cfg_idx  in  $clog2(TERMS)  term index
- cfg_care  in  IN_W  care mask (1 = literal used)
- cfg_val  in  IN_W  required literal polarity
- cfg_tgt  in  OUT_W  output bits this term flips
- cfg_en  in  1  term enable
- cfg_commit  in  1  pulse: copy shadow table to active table
- bypass  in  1  1 = out_y = base_y, no patch
- hit_cnt  out  CNT_W  count of valid cycles in which the applied patch was nonzero
- hit_clr  in  1  synchronous clear of hit_cnt

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_y=0, hit_cnt=0; all shadow and active terms have en=0, care=0, val=0, tgt=0; FSM enters IDLE; cfg_ready=0 while in reset.
- Term match: term t fires iff active.en[t] and ((in_vec ^ val[t]) & care[t]) == 0. A term with care=0 and en=1 fires on every input.
- Patch: patch = OR over fired terms of tgt[t]. A bit targeted by two fired terms flips once, not twice.
- Data path, 1-cycle latency:
  - On each clk, out_valid <= in_valid.
  - When in_valid=1: out_y <= base_y ^ (bypass ? 0 : patch).
  - When in_valid=0: out_y holds its value.
- Hit counter:
  - When in_valid=1, bypass=0 and patch != 0, hit_cnt increments and saturates at all-ones.
  - hit_clr has priority over increment; counter is 0 on the next cycle.
- Config FSM, states IDLE, COMMIT:
  - IDLE: cfg_ready=1. A write occurs when cfg_valid and cfg_ready; the shadow entry at cfg_idx takes {cfg_en, cfg_care, cfg_val, cfg_tgt} at that edge. cfg_commit goes to COMMIT.
  - cfg_valid and cfg_commit in the same cycle: the write lands in shadow first, and the commit copies the updated shadow.
  - COMMIT, exactly 1 cycle: cfg_ready=0. At the end of the cycle the whole active table is loaded from shadow. Return to IDLE.
  - cfg_commit asserted while in COMMIT is ignored.
- Data and commit ordering: data sampled in the COMMIT cycle uses the old active table. Data sampled in the following cycle uses the new table. The table never mixes old and new terms.
- cfg_idx ≥ TERMS (non-power-of-two synthesis only) is accepted and the write is dropped.
- Reset mid-commit aborts the copy; both tables clear.

Decomposition:
- Shared package eco_pkg:
  - term record typedef {en, care, val, tgt}, parameterised through localparams
  - FSM state enum {ST_IDLE, ST_COMMIT}
  - function cube_hit(vec, care, val)
- One sub-module, eco_cube_match: combinational; takes the active table and in_vec, returns the OUT_W patch vector. It is instantiated once and reused for formal equivalence against gate-level ECO netlists.

Test Plan:
- Reset then idle: out_valid=0, out_y=0, hit_cnt=0, cfg_ready=1 after reset release; base_y=3'b101 with in_valid passes unchanged to out_y one cycle later.
- Program term0 (care=10'h3FF, val=10'h2A5, tgt=3'b100, en=1), then commit. Apply in_vec=10'h2A5 with base_y=3'b001: out_y=3'b101 and hit_cnt=1. Apply in_vec=10'h2A4: out_y=3'b001 and hit_cnt stays 1.
- Overlap: term0 and term1 both target bit2 and both match, base_y=0 → out_y=3'b100, flipped once. With bypass=1 the same stimulus gives out_y=0 and hit_cnt does not change.
- Shadow isolation: write term2 but do not commit → no effect on out_y. Pulse cfg_commit → cfg_ready=0 for one cycle. A vector in that cycle uses the old table; the next cycle uses the new table.
- Simultaneous write and commit: cfg_valid and cfg_commit in the same cycle → the written term is active two cycles later.
- Counter edges: preload a condition that drives hit_cnt to 16'hFFFF, then one more hit → stays 16'hFFFF. hit_clr asserted together with a hit → 0. rst_n pulsed low during COMMIT → all outputs 0 and all terms disabled.

Source files
------------

// File: rtl/eco_pkg.sv
// Shared types and helpers for the ECO patch unit: term record, config FSM states
// and the single-cube match function used by the matcher.
package eco_pkg;

  // Widest primary-input vector the cube helper handles; callers zero-extend.
  localparam int unsigned MaxInW  = 64;
  localparam int unsigned DefInW  = 10;
  localparam int unsigned DefOutW = 3;

  typedef struct packed {
    logic               en;
    logic [DefInW-1:0]  care;
    logic [DefInW-1:0]  val;
    logic [DefOutW-1:0] tgt;
  } term_t;

  typedef enum logic {
    ST_IDLE,
    ST_COMMIT
  } cfg_state_e;

  // A cube hits when every cared-about literal matches its required polarity.
  function automatic logic cube_hit(input logic [MaxInW-1:0] vec,
                                    input logic [MaxInW-1:0] care,
                                    input logic [MaxInW-1:0] val);
    return ((vec ^ val) & care) == '0;
  endfunction

endpackage

// File: rtl/eco_cube_match.sv
// Combinational sum-of-products patch: OR of the target masks of every fired term.
// Kept standalone so it can be checked for equivalence against ECO netlists.
module eco_cube_match
  import eco_pkg::*;
#(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned TERMS = 4
) (
  input  logic [TERMS-1:0]            en,
  input  logic [TERMS-1:0][IN_W-1:0]  care,
  input  logic [TERMS-1:0][IN_W-1:0]  val,
  input  logic [TERMS-1:0][OUT_W-1:0] tgt,
  input  logic [IN_W-1:0]             in_vec,
  output logic [OUT_W-1:0]            patch
);

  logic [TERMS-1:0] fired;

  always_comb begin
    fired = '0;
    for (int t = 0; t < TERMS; t++) begin
      fired[t] = en[t] && cube_hit(MaxInW'(in_vec), MaxInW'(care[t]), MaxInW'(val[t]));
    end
  end

  // OR (not XOR) so a bit targeted by several fired terms flips exactly once.
  always_comb begin
    patch = '0;
    for (int t = 0; t < TERMS; t++) begin
      if (fired[t]) begin
        patch = patch | tgt[t];
      end
    end
  end

endmodule

// File: rtl/eco_patch_unit.sv
// Registered ECO rectification stage: XOR-corrects base_y with a programmable patch,
// with a double-buffered term table, bypass and a saturating hit counter.
module eco_patch_unit
  import eco_pkg::*;
#(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned TERMS = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_vec,
  input  logic [OUT_W-1:0]         base_y,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_y,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(TERMS)-1:0] cfg_idx,
  input  logic [IN_W-1:0]          cfg_care,
  input  logic [IN_W-1:0]          cfg_val,
  input  logic [OUT_W-1:0]         cfg_tgt,
  input  logic                     cfg_en,
  input  logic                     cfg_commit,
  input  logic                     bypass,
  output logic [CNT_W-1:0]         hit_cnt,
  input  logic                     hit_clr
);

  cfg_state_e state_q, state_d;

  logic [TERMS-1:0]            sh_en_q,   sh_en_d;
  logic [TERMS-1:0][IN_W-1:0]  sh_care_q, sh_care_d;
  logic [TERMS-1:0][IN_W-1:0]  sh_val_q,  sh_val_d;
  logic [TERMS-1:0][OUT_W-1:0] sh_tgt_q,  sh_tgt_d;

  logic [TERMS-1:0]            act_en_q;
  logic [TERMS-1:0][IN_W-1:0]  act_care_q;
  logic [TERMS-1:0][IN_W-1:0]  act_val_q;
  logic [TERMS-1:0][OUT_W-1:0] act_tgt_q;

  logic                        out_valid_q;
  logic [OUT_W-1:0]            out_y_q, out_y_d;
  logic [CNT_W-1:0]            hit_cnt_q, hit_cnt_d;

  logic                        idx_ok;
  logic                        wr_fire;
  logic                        load_active;
  logic [OUT_W-1:0]            patch;
  logic [OUT_W-1:0]            applied;
  logic                        hit;

  // ---------------------------------------------------------------------------
  // Config FSM
  // ---------------------------------------------------------------------------
  // Ready is forced low while reset is held, not just after the first edge.
  assign cfg_ready = rst_n && (state_q == ST_IDLE);
  assign idx_ok    = 32'(cfg_idx) < TERMS;
  assign wr_fire   = cfg_valid && cfg_ready && idx_ok;

  always_comb begin
    state_d     = state_q;
    load_active = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_commit) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        load_active = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and active term tables
  // ---------------------------------------------------------------------------
  always_comb begin
    sh_en_d   = sh_en_q;
    sh_care_d = sh_care_q;
    sh_val_d  = sh_val_q;
    sh_tgt_d  = sh_tgt_q;
    if (wr_fire) begin
      sh_en_d[cfg_idx]   = cfg_en;
      sh_care_d[cfg_idx] = cfg_care;
      sh_val_d[cfg_idx]  = cfg_val;
      sh_tgt_d[cfg_idx]  = cfg_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en_q   <= '0;
      sh_care_q <= '0;
      sh_val_q  <= '0;
      sh_tgt_q  <= '0;
    end else begin
      sh_en_q   <= sh_en_d;
      sh_care_q <= sh_care_d;
      sh_val_q  <= sh_val_d;
      sh_tgt_q  <= sh_tgt_d;
    end
  end

  // Whole-table copy in one edge, so data never sees a mix of old and new terms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_en_q   <= '0;
      act_care_q <= '0;
      act_val_q  <= '0;
      act_tgt_q  <= '0;
    end else if (load_active) begin
      act_en_q   <= sh_en_q;
      act_care_q <= sh_care_q;
      act_val_q  <= sh_val_q;
      act_tgt_q  <= sh_tgt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Data path
  // ---------------------------------------------------------------------------
  eco_cube_match #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .TERMS (TERMS)
  ) u_match (
    .en     (act_en_q),
    .care   (act_care_q),
    .val    (act_val_q),
    .tgt    (act_tgt_q),
    .in_vec (in_vec),
    .patch  (patch)
  );

  assign applied = bypass ? '0 : patch;
  assign hit     = in_valid && (applied != '0);

  always_comb begin
    out_y_d = out_y_q;
    if (in_valid) begin
      out_y_d = base_y ^ applied;
    end
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (hit_clr) begin
      hit_cnt_d = '0;
    end else if (hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      hit_cnt_q   <= '0;
    end else begin
      out_valid_q <= in_valid;
      out_y_q     <= out_y_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_eco_patch_unit.sv
// Self-checking bench for eco_patch_unit: vector table plus hand-written config/commit
// sequences, with a queue scoreboard checking every out_y beat.
module tb_eco_patch_unit;

  localparam int unsigned IN_W  = 10;
  localparam int unsigned OUT_W = 3;
  localparam int unsigned TERMS = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [IN_W-1:0]  in_vec;
  logic [OUT_W-1:0] base_y;
  logic             out_valid;
  logic [OUT_W-1:0] out_y;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_idx;
  logic [IN_W-1:0]  cfg_care;
  logic [IN_W-1:0]  cfg_val;
  logic [OUT_W-1:0] cfg_tgt;
  logic             cfg_en;
  logic             cfg_commit;
  logic             bypass;
  logic [CNT_W-1:0] hit_cnt;
  logic             hit_clr;

  eco_patch_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .TERMS (TERMS),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_vec     (in_vec),
    .base_y     (base_y),
    .out_valid  (out_valid),
    .out_y      (out_y),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_idx    (cfg_idx),
    .cfg_care   (cfg_care),
    .cfg_val    (cfg_val),
    .cfg_tgt    (cfg_tgt),
    .cfg_en     (cfg_en),
    .cfg_commit (cfg_commit),
    .bypass     (bypass),
    .hit_cnt    (hit_cnt),
    .hit_clr    (hit_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OUT_W-1:0] exp_q[$];

  typedef struct {
    logic [IN_W-1:0]  vec;
    logic [OUT_W-1:0] base;
    logic             byp;
    logic [OUT_W-1:0] exp_y;
    logic [CNT_W-1:0] exp_hit;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: every out_valid beat pops one expected value.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got out_y %0h, expected no output (t=%0t)", out_y, $time);
      end else begin
        logic [OUT_W-1:0] e;
        e = exp_q.pop_front();
        check("out_y", 32'(out_y), 32'(e));
      end
    end
  end

  task automatic apply(input logic [IN_W-1:0] vec, input logic [OUT_W-1:0] base,
                       input logic byp, input logic [OUT_W-1:0] ey);
    @(negedge clk);
    in_vec   = vec;
    base_y   = base;
    bypass   = byp;
    in_valid = 1'b1;
    exp_q.push_back(ey);
    @(negedge clk);
    in_valid = 1'b0;
    bypass   = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply(tbl[i].vec, tbl[i].base, tbl[i].byp, tbl[i].exp_y);
      check($sformatf("hit_cnt row%0d", i), 32'(hit_cnt), 32'(tbl[i].exp_hit));
    end
  endtask

  task automatic write_term(input logic [1:0] idx, input logic [IN_W-1:0] care,
                            input logic [IN_W-1:0] val, input logic [OUT_W-1:0] tgt,
                            input logic en);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_idx   = idx;
    cfg_care  = care;
    cfg_val   = val;
    cfg_tgt   = tgt;
    cfg_en    = en;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    check("cfg_ready in COMMIT", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    check("cfg_ready after COMMIT", 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    //        vec      base    byp   exp_y   exp_hit
    tbl[0] = '{10'h000, 3'b101, 1'b0, 3'b101, 16'd0};  // empty table: pass-through
    tbl[1] = '{10'h2A5, 3'b001, 1'b0, 3'b101, 16'd1};  // term0 fires
    tbl[2] = '{10'h2A4, 3'b001, 1'b0, 3'b001, 16'd1};  // one literal off
    tbl[3] = '{10'h2A5, 3'b000, 1'b0, 3'b100, 16'd2};  // term0+term1 overlap
    tbl[4] = '{10'h2A5, 3'b000, 1'b1, 3'b000, 16'd2};  // bypass
    tbl[5] = '{10'h000, 3'b000, 1'b0, 3'b100, 16'd3};  // care=0 term fires always
    tbl[6] = '{10'h155, 3'b000, 1'b0, 3'b100, 16'd4};  // uncommitted term2 inert

    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; base_y = '0; bypass = 1'b0;
    cfg_valid = 1'b0; cfg_idx = '0; cfg_care = '0; cfg_val = '0; cfg_tgt = '0;
    cfg_en = 1'b0; cfg_commit = 1'b0; hit_clr = 1'b0;

    repeat (3) @(negedge clk);
    check("reset cfg_ready", 32'(cfg_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_y", 32'(out_y), 32'd0);
    check("reset hit_cnt", 32'(hit_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle cfg_ready", 32'(cfg_ready), 32'd1);

    run_rows(0, 0);
    write_term(2'd0, 10'h3FF, 10'h2A5, 3'b100, 1'b1);
    commit();
    run_rows(1, 2);
    write_term(2'd1, 10'h000, 10'h000, 3'b100, 1'b1);
    commit();
    run_rows(3, 5);

    // Shadow isolation: term2 written, not yet committed.
    write_term(2'd2, 10'h3FF, 10'h155, 3'b010, 1'b1);
    run_rows(6, 6);

    // Commit held two cycles: the second cycle (in COMMIT) must be ignored.
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    check("ready during commit", 32'(cfg_ready), 32'd0);
    in_vec = 10'h155; base_y = 3'b000; in_valid = 1'b1;
    exp_q.push_back(3'b100);                 // old table in COMMIT cycle
    @(negedge clk);
    cfg_commit = 1'b0;
    check("ready after commit", 32'(cfg_ready), 32'd1);
    exp_q.push_back(3'b110);                 // new table next cycle
    @(negedge clk);
    in_valid = 1'b0;
    check("commit in COMMIT ignored", 32'(cfg_ready), 32'd1);
    check("hit_cnt after isolation", 32'(hit_cnt), 32'd6);

    // Simultaneous write and commit.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = 2'd3; cfg_care = 10'h3FF; cfg_val = 10'h0F0;
    cfg_tgt = 3'b001; cfg_en = 1'b1; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    in_vec = 10'h0F0; base_y = 3'b000; in_valid = 1'b1;
    exp_q.push_back(3'b100);
    @(negedge clk);
    exp_q.push_back(3'b101);
    @(negedge clk);
    in_valid = 1'b0;
    check("hit_cnt after write+commit", 32'(hit_cnt), 32'd8);

    // Saturation.
    @(negedge clk);
    hit_clr = 1'b1;
    @(negedge clk);
    hit_clr = 1'b0;
    check("hit_clr", 32'(hit_cnt), 32'd0);
    in_vec = 10'h000; base_y = 3'b000;
    for (int i = 0; i < 65540; i++) begin
      in_valid = 1'b1;
      exp_q.push_back(3'b100);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("hit_cnt saturated", 32'(hit_cnt), 32'hFFFF);
    apply(10'h000, 3'b000, 1'b0, 3'b100);
    check("hit_cnt stays saturated", 32'(hit_cnt), 32'hFFFF);

    // Clear wins over a simultaneous hit.
    @(negedge clk);
    hit_clr = 1'b1; in_valid = 1'b1; in_vec = 10'h000; base_y = 3'b000;
    exp_q.push_back(3'b100);
    @(negedge clk);
    hit_clr = 1'b0; in_valid = 1'b0;
    check("hit_clr priority", 32'(hit_cnt), 32'd0);
    apply(10'h000, 3'b000, 1'b0, 3'b100);
    check("hit_cnt after clr", 32'(hit_cnt), 32'd1);

    // Reset asserted during COMMIT.
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst mid-commit out_y", 32'(out_y), 32'd0);
    check("rst mid-commit hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst mid-commit cfg_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(10'h000, 3'b000, 1'b0, 3'b000);
    check("terms disabled hit_cnt", 32'(hit_cnt), 32'd0);
    commit();
    apply(10'h0F0, 3'b010, 1'b0, 3'b010);
    check("shadow cleared hit_cnt", 32'(hit_cnt), 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
